axi256_burst_master: RTL and testbench



---
 rtl/axi256_burst_master.sv | 172 +++++++++++++++++
 tb/tb_axi256_burst_master.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi256_burst_master.sv
// Single-outstanding AXI4 INCR burst initiator for the 256-bit DDR port.
// Turns one client command into an address phase, its data beats and a completion pulse.
module axi256_burst_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_wr_i,
    input  logic [ADDR_W-1:0]     cmd_addr_i,
    input  logic [7:0]            cmd_len_i,
    input  logic                  wr_valid_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic [DATA_W/8-1:0]   wr_strb_i,
    output logic                  wr_ready_o,
    output logic                  rd_valid_o,
    output logic [DATA_W-1:0]     rd_data_o,
    input  logic                  rd_ready_i,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  outport_awvalid_o,
    input  logic                  outport_awready_i,
    output logic [ADDR_W-1:0]     outport_awaddr_o,
    output logic [7:0]            outport_awlen_o,
    output logic                  outport_wvalid_o,
    input  logic                  outport_wready_i,
    output logic [DATA_W-1:0]     outport_wdata_o,
    output logic [DATA_W/8-1:0]   outport_wstrb_o,
    output logic                  outport_wlast_o,
    input  logic                  outport_bvalid_i,
    output logic                  outport_bready_o,
    input  logic [1:0]            outport_bresp_i,
    output logic                  outport_arvalid_o,
    input  logic                  outport_arready_i,
    output logic [ADDR_W-1:0]     outport_araddr_o,
    output logic [7:0]            outport_arlen_o,
    input  logic                  outport_rvalid_i,
    output logic                  outport_rready_o,
    input  logic [DATA_W-1:0]     outport_rdata_i,
    input  logic [1:0]            outport_rresp_i,
    input  logic                  outport_rlast_i
);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          len_q;
    logic [7:0]          cnt_q;
    logic                rerr_q;
    logic                done_q;
    logic                err_q;

    // Bursts must stay inside one 4KB page: 32-byte beat index plus len may not pass 127.
    logic [8:0] page_end;
    logic       cross_4k;
    assign page_end = {2'b00, cmd_addr_i[11:5]} + {1'b0, cmd_len_i};
    assign cross_4k = page_end > 9'd127;

    logic last_beat, w_hs, r_hs, beat_err;
    assign last_beat = (cnt_q == len_q);
    assign w_hs      = outport_wvalid_o & outport_wready_i;
    assign r_hs      = outport_rvalid_i & outport_rready_o;
    assign beat_err  = (outport_rresp_i != 2'b00) || (outport_rlast_i && !last_beat) ||
                       (last_beat && !outport_rlast_i);

    assign done_o           = done_q;
    assign err_o            = err_q;
    assign outport_awaddr_o = addr_q;
    assign outport_araddr_o = addr_q;
    assign outport_awlen_o  = len_q;
    assign outport_arlen_o  = len_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d           = state_q;
        cmd_ready_o       = 1'b0;
        outport_awvalid_o = 1'b0;
        outport_arvalid_o = 1'b0;
        outport_wvalid_o  = 1'b0;
        outport_wdata_o   = '0;
        outport_wstrb_o   = '0;
        outport_wlast_o   = 1'b0;
        wr_ready_o        = 1'b0;
        outport_bready_o  = 1'b0;
        outport_rready_o  = 1'b0;
        rd_valid_o        = 1'b0;
        rd_data_o         = '0;
        case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i && !cross_4k) state_d = cmd_wr_i ? S_AW : S_AR;
            end
            S_AW: begin
                outport_awvalid_o = 1'b1;
                if (outport_awready_i) state_d = S_W;
            end
            S_W: begin
                outport_wvalid_o = wr_valid_i;
                outport_wdata_o  = wr_data_i;
                outport_wstrb_o  = wr_strb_i;
                outport_wlast_o  = last_beat;
                wr_ready_o       = outport_wready_i;
                if (wr_valid_i && outport_wready_i && last_beat) state_d = S_B;
            end
            S_B: begin
                outport_bready_o = 1'b1;
                if (outport_bvalid_i) state_d = S_IDLE;
            end
            S_AR: begin
                outport_arvalid_o = 1'b1;
                if (outport_arready_i) state_d = S_R;
            end
            S_R: begin
                rd_valid_o       = outport_rvalid_i;
                rd_data_o        = outport_rdata_i;
                outport_rready_o = rd_ready_i;
                if (outport_rvalid_i && rd_ready_i && (outport_rlast_i || last_beat))
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            rerr_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: if (cmd_valid_i) begin
                    addr_q <= cmd_addr_i & ~{{(ADDR_W-5){1'b0}}, 5'h1f};
                    len_q  <= cmd_len_i;
                    rerr_q <= 1'b0;
                    if (cross_4k) begin
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                    end
                end
                S_AW: if (outport_awready_i) cnt_q <= '0;
                S_AR: if (outport_arready_i) cnt_q <= '0;
                S_W:  if (w_hs) cnt_q <= cnt_q + 8'd1;
                S_B: if (outport_bvalid_i) begin
                    done_q <= 1'b1;
                    err_q  <= (outport_bresp_i != 2'b00);
                end
                S_R: if (r_hs) begin
                    cnt_q  <= cnt_q + 8'd1;
                    rerr_q <= rerr_q | beat_err;
                    if (outport_rlast_i || last_beat) begin
                        done_q <= 1'b1;
                        err_q  <= rerr_q | beat_err;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi256_burst_master.sv
// Directed bench for axi256_burst_master: write/read bursts, 4KB rejection, error
// responses and mid-burst reset, each step checked with an immediate assertion.
module tb_axi256_burst_master;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic         cmd_valid_i, cmd_ready_o, cmd_wr_i;
    logic [31:0]  cmd_addr_i;
    logic [7:0]   cmd_len_i;
    logic         wr_valid_i, wr_ready_o;
    logic [255:0] wr_data_i;
    logic [31:0]  wr_strb_i;
    logic         rd_valid_o, rd_ready_i;
    logic [255:0] rd_data_o;
    logic         done_o, err_o;
    logic         awvalid, awready, arvalid, arready;
    logic [31:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic         wvalid, wready, wlast, bvalid, bready, rvalid, rready, rlast;
    logic [255:0] wdata, rdata;
    logic [31:0]  wstrb;
    logic [1:0]   bresp, rresp;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    axi256_burst_master dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .wr_strb_i(wr_strb_i), .wr_ready_o(wr_ready_o),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_ready_i(rd_ready_i),
        .done_o(done_o), .err_o(err_o),
        .outport_awvalid_o(awvalid), .outport_awready_i(awready),
        .outport_awaddr_o(awaddr), .outport_awlen_o(awlen),
        .outport_wvalid_o(wvalid), .outport_wready_i(wready), .outport_wdata_o(wdata),
        .outport_wstrb_o(wstrb), .outport_wlast_o(wlast),
        .outport_bvalid_i(bvalid), .outport_bready_o(bready), .outport_bresp_i(bresp),
        .outport_arvalid_o(arvalid), .outport_arready_i(arready),
        .outport_araddr_o(araddr), .outport_arlen_o(arlen),
        .outport_rvalid_i(rvalid), .outport_rready_o(rready), .outport_rdata_i(rdata),
        .outport_rresp_i(rresp), .outport_rlast_i(rlast)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) if (done_o) done_cnt <= done_cnt + 1;

    function automatic logic [255:0] beat(input int i);
        return {8{32'hA5A5_0000 + 32'(i)}};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [7:0] len);
        tick();
        cmd_valid_i = 1'b1; cmd_wr_i = wr; cmd_addr_i = addr; cmd_len_i = len;
        settle();
        chk("cmd_ready_idle", cmd_ready_o, 1);
        tick();
        cmd_valid_i = 1'b0;
    endtask

    initial begin
        int k, dc;
        logic rv, rr;
        rst_n_i = 1'b0; cmd_valid_i = 0; cmd_wr_i = 0; cmd_addr_i = 0; cmd_len_i = 0;
        wr_valid_i = 0; wr_data_i = 0; wr_strb_i = 0; rd_ready_i = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
        rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
        #3;
        chk("reset_ctrl", {awvalid, arvalid, wvalid, wr_ready_o, bready, rready, rd_valid_o, done_o, err_o}, 0);
        chk("reset_addr_len", {awaddr, araddr, awlen, arlen}, 0);
        tick(); tick();
        rst_n_i = 1'b1;

        // Write 0x1000_0020 len 3; W data offered early must not leak before AW handshake
        wready = 1; wr_valid_i = 1; wr_data_i = beat(0); wr_strb_i = '1;
        issue(1'b1, 32'h1000_0020, 8'd3);
        settle();
        chk("aw_valid", awvalid, 1);
        chk("aw_addr_len", {awaddr, awlen}, {32'h1000_0020, 8'd3});
        chk("no_w_before_aw", {wvalid, wr_ready_o}, 0);
        tick();
        awready = 1;
        settle();
        chk("aw_stable", {awvalid, awaddr, awlen}, {1'b1, 32'h1000_0020, 8'd3});
        tick();
        awready = 0;
        for (int i = 0; i < 4; i++) begin
            wr_data_i = beat(i);
            settle();
            chk("w_beat", {wvalid, wr_ready_o, wlast, wstrb}, {1'b1, 1'b1, (i == 3), 32'hFFFF_FFFF});
            chk("w_data", wdata, beat(i));
            tick();
        end
        wr_valid_i = 0; bvalid = 1; bresp = 0;
        settle();
        chk("b_ready", {bready, wvalid, done_o}, 3'b100);
        tick();
        bvalid = 0;
        settle();
        chk("wr_done", {done_o, err_o, cmd_ready_o}, 3'b101);
        tick();
        settle();
        chk("done_one_cycle", done_o, 0);

        // Read 0x40 len 7 with random slave gaps and client backpressure
        issue(1'b0, 32'h0000_0040, 8'd7);
        arready = 1;
        settle();
        chk("ar_phase", {arvalid, awvalid, araddr, arlen}, {2'b10, 32'h0000_0040, 8'd7});
        tick();
        arready = 0;
        k = 0;
        for (int c = 0; c < 200 && k < 8; c++) begin
            rv = 1'($urandom_range(0, 1)); rr = 1'($urandom_range(0, 1));
            rvalid = rv; rready_set: rd_ready_i = rr;
            rdata = beat(k + 16); rlast = (k == 7); rresp = 0;
            settle();
            chk("rd_fwd", {rd_valid_o, rready, done_o}, {rv, rr, 1'b0});
            if (rv && rr) begin
                chk("rd_data", rd_data_o, beat(k + 16));
                k++;
            end
            tick();
        end
        rvalid = 0; rd_ready_i = 0; rlast = 0;
        chk("rd_beat_count", k, 8);
        settle();
        chk("rd_done", {done_o, err_o}, 2'b10);

        // 0x0FE0 len 1 crosses the 4KB page: error completion, no bus activity
        issue(1'b1, 32'h0000_0FE0, 8'd1);
        settle();
        chk("4k_done", {done_o, err_o, awvalid, arvalid, cmd_ready_o}, 5'b11001);
        tick();
        settle();
        chk("4k_after", {done_o, awvalid, arvalid}, 0);

        // Read 0xF80 len 3 ends exactly at the page edge; slave errors on beat 1
        issue(1'b0, 32'h0000_0F80, 8'd3);
        arready = 1;
        settle();
        chk("edge_ar", {arvalid, araddr}, {1'b1, 32'h0000_0F80});
        tick();
        arready = 0; rvalid = 1; rd_ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            rdata = beat(i + 32); rresp = (i == 1) ? 2'b10 : 2'b00; rlast = (i == 3);
            settle();
            chk("rerr_beat", {rd_valid_o, rd_data_o}, {1'b1, beat(i + 32)});
            tick();
        end
        rvalid = 0; rd_ready_i = 0; rlast = 0; rresp = 0;
        settle();
        chk("rerr_done", {done_o, err_o}, 2'b11);

        // Single-beat write with SLVERR
        issue(1'b1, 32'h2000_0000, 8'd0);
        awready = 1;
        settle();
        chk("len0_aw", {awvalid, awlen}, {1'b1, 8'd0});
        tick();
        awready = 0; wr_valid_i = 1; wr_data_i = beat(48);
        settle();
        chk("len0_wlast", {wvalid, wlast}, 2'b11);
        tick();
        wr_valid_i = 0; bvalid = 1; bresp = 2'b10;
        settle();
        tick();
        bvalid = 0; bresp = 0;
        settle();
        chk("bresp_err_done", {done_o, err_o}, 2'b11);

        // Reset during W beat 2 of an 8-beat write
        issue(1'b1, 32'h3000_0000, 8'd7);
        awready = 1;
        tick();
        awready = 0; wr_valid_i = 1;
        for (int i = 0; i < 2; i++) begin
            wr_data_i = beat(i);
            tick();
        end
        wr_data_i = beat(2);
        settle();
        chk("pre_reset_w", {wvalid, wlast}, 2'b10);
        dc = done_cnt;
        #1 rst_n_i = 1'b0;
        #1;
        chk("async_reset", {wvalid, wr_ready_o, awvalid, bready, done_o, err_o, awaddr}, 0);
        wr_valid_i = 0;
        tick(); tick();
        chk("no_done_on_reset", done_cnt, dc);
        rst_n_i = 1'b1;
        issue(1'b0, 32'h0000_005F, 8'd0);
        arready = 1;
        settle();
        chk("post_reset_ar", {arvalid, araddr, arlen}, {1'b1, 32'h0000_0040, 8'd0});
        tick();
        arready = 0; rvalid = 1; rd_ready_i = 1; rlast = 1; rdata = beat(64);
        settle();
        chk("post_reset_rd", {rd_valid_o, rd_data_o}, {1'b1, beat(64)});
        tick();
        rvalid = 0; rd_ready_i = 0; rlast = 0;
        settle();
        chk("post_reset_done", {done_o, err_o}, 2'b10);
        tick();
        settle();
        chk("done_pulse_total", done_cnt, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
